// File: rtl/run_step_control.sv
// Run/stop/step controller: debounced EXEC/STEP buttons and core HALT drive a datapath clock enable.
// Optional single-step support is built only when RUN_STEP_CONTROL_STEP_EN is defined.
module run_step_control_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic raw_i,
    output logic press_o
);

    localparam int DW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic          q1_q;
    logic          q2_q;
    logic          level_q;
    logic          level_dly_q;
    logic [DW-1:0] cnt_q;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            q1_q        <= 1'b0;
            q2_q        <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            q1_q        <= raw_i;
            q2_q        <= q1_q;
            level_dly_q <= level_q;
            if (q2_q != level_q) begin
                // Accept the new level on the Nth consecutive differing edge.
                if (cnt_q == LAST) begin
                    level_q <= q2_q;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + DW'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign press_o = level_q & ~level_dly_q;

endmodule

module run_step_control #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             EXEC,
    input  logic             STEP,
    input  logic             HALT,
    output logic             CLK_EN,
    output logic             RUNNING,
    output logic             HALTED,
    output logic [CNT_W-1:0] CYCLE_COUNT
);

    typedef enum logic [1:0] {
        S_STOP   = 2'd0,
        S_RUN    = 2'd1,
        S_STEP   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             clk_en_q;
    logic             running_q;
    logic             halted_q;
    logic [CNT_W-1:0] count_q;
    logic             exec_press;
    logic             step_press;

    run_step_control_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_exec_db (
        .CLOCK  (CLOCK),
        .RESET  (RESET),
        .raw_i  (EXEC),
        .press_o(exec_press)
    );

`ifdef RUN_STEP_CONTROL_STEP_EN
    run_step_control_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_db (
        .CLOCK  (CLOCK),
        .RESET  (RESET),
        .raw_i  (STEP),
        .press_o(step_press)
    );
`else
    logic unused_step;
    assign unused_step = STEP;
    assign step_press  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_STOP: begin
                if (exec_press)
                    state_d = S_RUN;
`ifdef RUN_STEP_CONTROL_STEP_EN
                else if (step_press)
                    state_d = S_STEP;
`endif
            end
            S_RUN: begin
                if (HALT)
                    state_d = S_HALTED;
                else if (exec_press)
                    state_d = S_STOP;
            end
            S_STEP: begin
                state_d = HALT ? S_HALTED : S_STOP;
            end
            S_HALTED: begin
                if (exec_press && !HALT)
                    state_d = S_STOP;
            end
            default: state_d = S_STOP;
        endcase
    end

    // Outputs are registered copies of the next-state decode.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q   <= S_STOP;
            clk_en_q  <= 1'b0;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_en_q  <= (state_d == S_RUN) || (state_d == S_STEP);
            running_q <= (state_d == S_RUN);
            halted_q  <= (state_d == S_HALTED);
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET)
            count_q <= '0;
        else if (clk_en_q && (count_q != {CNT_W{1'b1}}))
            count_q <= count_q + CNT_W'(1);
    end

    assign CLK_EN      = clk_en_q;
    assign RUNNING     = running_q;
    assign HALTED      = halted_q;
    assign CYCLE_COUNT = count_q;

endmodule
